// File: rtl/ring_marquee.sv
// ring_marquee: WIDTH-bit rotating ring with a prescaler, wrap/bounce modes,
// parallel load and a tracked rotation offset for a downstream decoder.
module ring_marquee #(
   parameter int                 WIDTH         = 13,
   parameter int                 PRESCALE_W    = 8,
   parameter logic [WIDTH-1:0]   RESET_PATTERN = {{(WIDTH-1){1'b1}}, 1'b0}
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      en,
   input  logic                      dir,
   input  logic                      mode,
   input  logic [PRESCALE_W-1:0]     period,
   input  logic                      load,
   input  logic [WIDTH-1:0]          load_data,
   output logic [WIDTH-1:0]          pattern,
   output logic [$clog2(WIDTH)-1:0]  pos,
   output logic                      cur_dir,
   output logic                      step_pulse
);

   localparam int               POS_W   = $clog2(WIDTH);
   localparam logic [POS_W-1:0] POS_MAX = POS_W'(WIDTH - 1);

   logic [PRESCALE_W-1:0] cnt;
   logic                  tick;
   logic                  step_dn;
   logic                  nxt_dir;
   logic [WIDTH-1:0]      rot_up;
   logic [WIDTH-1:0]      rot_dn;
   logic [POS_W-1:0]      pos_up;
   logic [POS_W-1:0]      pos_dn;

   // A tick fires once cnt reaches period; ">=" makes a lowered period
   // take effect on the next enabled cycle instead of wrapping the counter.
   assign tick = en && (cnt >= period);

   // Direction of the next step plus the rotated candidates in both directions.
   // Bounce turns around at the ends and steps away in the same tick.
   always_comb begin
      step_dn = dir;
      nxt_dir = dir;
      if (mode) begin
         step_dn = cur_dir;
         nxt_dir = cur_dir;
         if (!cur_dir && pos == POS_MAX) begin
            step_dn = 1'b1;
            nxt_dir = 1'b1;
         end else if (cur_dir && pos == '0) begin
            step_dn = 1'b0;
            nxt_dir = 1'b0;
         end
      end
      rot_up = {pattern[WIDTH-2:0], pattern[WIDTH-1]};
      rot_dn = {pattern[0], pattern[WIDTH-1:1]};
      pos_up = (pos == POS_MAX) ? '0 : pos + POS_W'(1);
      pos_dn = (pos == '0) ? POS_MAX : pos - POS_W'(1);
   end

   // Ring state: reset > load > step > hold; step_pulse marks the cycle
   // in which the freshly rotated value is visible.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pattern    <= RESET_PATTERN;
         pos        <= '0;
         cnt        <= '0;
         cur_dir    <= 1'b0;
         step_pulse <= 1'b0;
      end else if (load) begin
         pattern    <= load_data;
         pos        <= '0;
         cnt        <= '0;
         cur_dir    <= dir;
         step_pulse <= 1'b0;
      end else begin
         step_pulse <= tick;
         if (tick) begin
            cnt     <= '0;
            pattern <= step_dn ? rot_dn : rot_up;
            pos     <= step_dn ? pos_dn : pos_up;
            cur_dir <= nxt_dir;
         end else if (en) begin
            cnt <= cnt + PRESCALE_W'(1);
         end
      end
   end

endmodule
